// File: rtl/page_pair_dfx_sequencer_if.sv
// Page-side bundle of the DFX page-pair sequencer: raw page outputs in, decoupled leaf
// data and per-page reset/resend/ap_start controls out.
interface page_pair_dfx_sequencer_if #(
  parameter int unsigned DW = 49
);
  logic [DW-1:0] page_dout_0;
  logic [DW-1:0] page_dout_1;
  logic [DW-1:0] leaf_dout_0;
  logic [DW-1:0] leaf_dout_1;
  logic          page_reset_0;
  logic          page_reset_1;
  logic          page_resend_0;
  logic          page_resend_1;
  logic          page_ap_start_0;
  logic          page_ap_start_1;

  modport master (
    input  page_dout_0, page_dout_1,
    output leaf_dout_0, leaf_dout_1,
    output page_reset_0, page_reset_1,
    output page_resend_0, page_resend_1,
    output page_ap_start_0, page_ap_start_1
  );

  modport slave (
    output page_dout_0, page_dout_1,
    input  leaf_dout_0, leaf_dout_1,
    input  page_reset_0, page_reset_1,
    input  page_resend_0, page_resend_1,
    input  page_ap_start_0, page_ap_start_1
  );
endinterface

// File: rtl/page_pair_dfx_sequencer.sv
// Sequences two DFX leaf pages through reconfig, reset, resend and ap_start, decoupling
// each page's leaf output until it runs and sharing one resend slot round-robin.
module page_pair_dfx_sequencer #(
  parameter int unsigned DW            = 49,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned RESEND_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    rp_reconfig,
  input  logic [1:0]                    rp_start,
  output logic [1:0]                    running,
  page_pair_dfx_sequencer_if.master     pg
);

  localparam int unsigned CMAX = (RST_CYCLES > RESEND_CYCLES) ? RST_CYCLES : RESEND_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECONF,
    S_RST_HOLD,
    S_WAIT_GNT,
    S_RESEND,
    S_RUN
  } state_t;

  typedef struct packed {
    state_t        st;
    logic [CW-1:0] cnt;
  } step_t;

  state_t        state_0, state_1;
  logic [CW-1:0] cnt_0, cnt_1;
  logic          prio;
  logic          prio_nxt;
  logic [1:0]    req, busy, gnt;
  step_t         nxt_0, nxt_1;

  function automatic step_t step(input state_t f_st, input logic [CW-1:0] f_cnt,
                                 input logic f_start, input logic f_reconf, input logic f_gnt);
    step_t r;
    r.st  = f_st;
    r.cnt = f_cnt;
    if (f_reconf) begin
      r.st  = S_RECONF;
      r.cnt = '0;
    end else begin
      case (f_st)
        S_IDLE: if (f_start) begin
          r.st  = S_RST_HOLD;
          r.cnt = '0;
        end
        S_RECONF: r.st = S_IDLE;
        S_RST_HOLD: begin
          if (!f_start) begin
            r.st  = S_IDLE;
            r.cnt = '0;
          end else if (f_cnt == CW'(RST_CYCLES - 1)) begin
            r.st  = S_WAIT_GNT;
            r.cnt = '0;
          end else begin
            r.cnt = f_cnt + 1'b1;
          end
        end
        S_WAIT_GNT: begin
          if (!f_start) begin
            r.st = S_IDLE;
          end else if (f_gnt) begin
            r.st  = S_RESEND;
            r.cnt = '0;
          end
        end
        S_RESEND: begin
          if (!f_start) begin
            r.st  = S_IDLE;
            r.cnt = '0;
          end else if (f_cnt == CW'(RESEND_CYCLES - 1)) begin
            r.st  = S_RUN;
            r.cnt = '0;
          end else begin
            r.cnt = f_cnt + 1'b1;
          end
        end
        S_RUN: if (!f_start) r.st = S_IDLE;
        default: begin
          r.st  = S_IDLE;
          r.cnt = '0;
        end
      endcase
    end
    return r;
  endfunction

  // An aborting page (reconfig or stop) frees the slot in the same cycle; a normal
  // RESEND completion frees it only once the page has actually left RESEND.
  always_comb begin
    req[0]   = (state_0 == S_WAIT_GNT) && rp_start[0] && !rp_reconfig[0];
    req[1]   = (state_1 == S_WAIT_GNT) && rp_start[1] && !rp_reconfig[1];
    busy[0]  = (state_0 == S_RESEND) && rp_start[0] && !rp_reconfig[0];
    busy[1]  = (state_1 == S_RESEND) && rp_start[1] && !rp_reconfig[1];
    gnt      = '0;
    prio_nxt = prio;
    if (busy == '0) begin
      if (req == 2'b11) begin
        gnt      = prio ? 2'b10 : 2'b01;
        prio_nxt = ~prio;
      end else begin
        gnt = req;
      end
    end
    nxt_0 = step(state_0, cnt_0, rp_start[0], rp_reconfig[0], gnt[0]);
    nxt_1 = step(state_1, cnt_1, rp_start[1], rp_reconfig[1], gnt[1]);
  end

  // Outputs are registered from the next state so the first RUN cycle already forwards data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_0            <= S_IDLE;
      state_1            <= S_IDLE;
      cnt_0              <= '0;
      cnt_1              <= '0;
      prio               <= 1'b0;
      running            <= '0;
      pg.leaf_dout_0     <= '0;
      pg.leaf_dout_1     <= '0;
      pg.page_reset_0    <= 1'b1;
      pg.page_reset_1    <= 1'b1;
      pg.page_resend_0   <= 1'b0;
      pg.page_resend_1   <= 1'b0;
      pg.page_ap_start_0 <= 1'b0;
      pg.page_ap_start_1 <= 1'b0;
    end else begin
      state_0            <= nxt_0.st;
      state_1            <= nxt_1.st;
      cnt_0              <= nxt_0.cnt;
      cnt_1              <= nxt_1.cnt;
      prio               <= prio_nxt;
      running[0]         <= (nxt_0.st == S_RUN);
      running[1]         <= (nxt_1.st == S_RUN);
      pg.leaf_dout_0     <= (nxt_0.st == S_RUN) ? pg.page_dout_0 : '0;
      pg.leaf_dout_1     <= (nxt_1.st == S_RUN) ? pg.page_dout_1 : '0;
      pg.page_reset_0    <= (nxt_0.st == S_IDLE) || (nxt_0.st == S_RECONF) || (nxt_0.st == S_RST_HOLD);
      pg.page_reset_1    <= (nxt_1.st == S_IDLE) || (nxt_1.st == S_RECONF) || (nxt_1.st == S_RST_HOLD);
      pg.page_resend_0   <= (nxt_0.st == S_RESEND);
      pg.page_resend_1   <= (nxt_1.st == S_RESEND);
      pg.page_ap_start_0 <= (nxt_0.st == S_RUN);
      pg.page_ap_start_1 <= (nxt_1.st == S_RUN);
    end
  end

endmodule
